// File: rtl/ifetch_unit.sv
// Minisys instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the instruction for decode and resolves the next PC on retire.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [5:0]  Opcode,
    output logic [5:0]  Function_opcode,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        stall,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Zero,
    input  logic [31:0] Read_data_1,
    output logic [31:0] PC_plus_4,
    output logic [31:0] link_addr,
    output logic        pc_misalign
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] link_q, link_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_plus_4;
    logic [31:0] branch_offset;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic        retire;
    logic [31:0] next_pc;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            link_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            link_q     <= link_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_plus_4 = pc_q + 32'd4;

    always_comb begin
        branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        jump_target   = {pc_plus_4[31:28], instr_q[25:0], 2'b00};
        branch_taken  = (Branch & Zero) | (nBranch & ~Zero);
        retire        = (state_q == S_EXEC) && exec_done && !stall;

        if (Jr) begin
            next_pc = Read_data_1;
        end else if (Jmp || Jal) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = pc_plus_4 + branch_offset;
        end else begin
            next_pc = pc_plus_4;
        end

        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        link_d     = link_q;
        misalign_d = misalign_q;

        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (retire) begin
                    if (Jal) begin
                        link_d = pc_plus_4;
                    end
                    // A misaligned target freezes the PC at the offending instruction.
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_comb begin
        imem_req        = (state_q == S_FETCH);
        instr_valid     = (state_q == S_EXEC);
        imem_addr       = pc_q;
        Instruction     = instr_q;
        Opcode          = instr_q[31:26];
        Function_opcode = instr_q[5:0];
        PC_plus_4       = pc_plus_4;
        link_addr       = link_q;
        pc_misalign     = misalign_q;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random traffic, every cycle
// compared against a transaction-level fetch/retire model.
module tb_ifetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [5:0]  Opcode;
    logic [5:0]  Function_opcode;
    logic        instr_valid;
    logic        exec_done;
    logic        stall;
    logic        Branch, nBranch, Jmp, Jal, Jr, Zero;
    logic [31:0] Read_data_1;
    logic [31:0] PC_plus_4;
    logic [31:0] link_addr;
    logic        pc_misalign;

    always #5 clock = ~clock;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .Instruction(Instruction),
        .Opcode(Opcode),
        .Function_opcode(Function_opcode),
        .instr_valid(instr_valid),
        .exec_done(exec_done),
        .stall(stall),
        .Branch(Branch),
        .nBranch(nBranch),
        .Jmp(Jmp),
        .Jal(Jal),
        .Jr(Jr),
        .Zero(Zero),
        .Read_data_1(Read_data_1),
        .PC_plus_4(PC_plus_4),
        .link_addr(link_addr),
        .pc_misalign(pc_misalign)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: which instruction the core holds, if any, and whether it halted.
    logic [31:0] m_pc, m_instr, m_link;
    bit          m_have, m_halt, m_mis;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_BR   = 5'b10000;
    localparam logic [4:0] F_NBR  = 5'b01000;
    localparam logic [4:0] F_JMP  = 5'b00100;
    localparam logic [4:0] F_JAL  = 5'b00010;
    localparam logic [4:0] F_JR   = 5'b00001;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] BEQ3 = 32'h1000_0003;
    localparam logic [31:0] BNEM = 32'h1400_FFFF;
    localparam logic [31:0] J10  = 32'h0800_0004;
    localparam logic [31:0] J40  = 32'h0800_0010;
    localparam logic [31:0] JAL  = 32'h0C00_0040;
    localparam logic [31:0] JR   = 32'h03E0_0008;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic [31:0] p4, nxt;
        int          off;
        if (!reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_link = 32'h0;
            m_have = 0; m_halt = 0; m_mis = 0;
        end else if (m_halt) begin
            // frozen until reset
        end else if (!m_have) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_have  = 1;
            end
        end else if (exec_done && !stall) begin
            p4  = m_pc + 32'd4;
            off = $signed(m_instr[15:0]);
            if (Jr)                                     nxt = Read_data_1;
            else if (Jmp || Jal)                        nxt = (p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
            else if ((Branch && Zero) || (nBranch && !Zero)) nxt = p4 + 32'(off * 4);
            else                                        nxt = p4;
            if (Jal) m_link = p4;
            if (nxt % 4 != 0) begin
                m_mis  = 1;
                m_halt = 1;
            end else begin
                m_pc   = nxt;
                m_have = 0;
            end
        end
    endtask

    // Compare all outputs to the model, then advance one clock.
    task automatic cycle();
        chk("imem_req",    {31'b0, imem_req},    {31'b0, !m_halt && !m_have});
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have && !m_halt});
        chk("imem_addr",   imem_addr,            m_pc);
        chk("Instruction", Instruction,          m_instr);
        chk("Opcode",      {26'b0, Opcode},      m_instr >> 26);
        chk("Function",    {26'b0, Function_opcode}, m_instr & 32'h3F);
        chk("PC_plus_4",   PC_plus_4,            m_pc + 32'd4);
        chk("link_addr",   link_addr,            m_link);
        chk("pc_misalign", {31'b0, pc_misalign}, {31'b0, m_mis});
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic clear_ctrl();
        {Branch, nBranch, Jmp, Jal, Jr} = F_NONE;
        Zero = 1'b0; exec_done = 1'b0; stall = 1'b0; Read_data_1 = 32'h0;
    endtask

    // One fetch (after ack_delay idle cycles) followed by a retire after stall_cycles.
    task automatic run_instr(input logic [31:0] word, input logic [4:0] flags, input logic zero,
                             input logic [31:0] rd1, input int unsigned ack_delay,
                             input int unsigned stall_cycles);
        clear_ctrl();
        imem_ack = 1'b0;
        for (int unsigned i = 0; i < ack_delay; i++) begin
            imem_rdata = $urandom;
            cycle();
        end
        imem_ack = 1'b1; imem_rdata = word;
        cycle();
        imem_ack = 1'b0; imem_rdata = $urandom;
        {Branch, nBranch, Jmp, Jal, Jr} = flags;
        Zero = zero; Read_data_1 = rd1; exec_done = 1'b1;
        stall = 1'b1;
        for (int unsigned i = 0; i < stall_cycles; i++) cycle();
        stall = 1'b0;
        cycle();
        clear_ctrl();
    endtask

    initial begin
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        clear_ctrl();
        @(posedge clock);
        model_step();
        #1;
        cycle();
        reset = 1'b1;
        chk("rst_req",  {31'b0, imem_req}, 32'h1);
        chk("rst_addr", imem_addr, 32'h0);

        run_instr(NOP, F_NONE, 1'b0, 32'h0, 0, 0);
        chk("seq_addr4", imem_addr, 32'h4);
        run_instr(NOP, F_NONE, 1'b0, 32'h0, 0, 0);
        chk("seq_addr8", imem_addr, 32'h8);

        run_instr(NOP, F_NONE, 1'b0, 32'h0, 2, 0);
        chk("lat_addr", imem_addr, 32'hC);
        run_instr(NOP, F_NONE, 1'b0, 32'h0, 0, 0);

        run_instr(BEQ3, F_BR, 1'b1, 32'h0, 0, 0);
        chk("beq_taken", imem_addr, 32'h20);
        run_instr(J10, F_JMP, 1'b0, 32'h0, 1, 0);
        chk("j_0x10", imem_addr, 32'h10);
        run_instr(BEQ3, F_BR, 1'b0, 32'h0, 0, 0);
        chk("beq_not_taken", imem_addr, 32'h14);
        run_instr(J10, F_JMP, 1'b0, 32'h0, 0, 0);
        run_instr(BNEM, F_NBR, 1'b0, 32'h0, 0, 0);
        chk("bne_self", imem_addr, 32'h10);

        run_instr(J40, F_JMP, 1'b0, 32'h0, 0, 0);
        chk("j_0x40", imem_addr, 32'h40);
        run_instr(JAL, F_JAL, 1'b0, 32'h0, 0, 2);
        chk("jal_link", link_addr, 32'h44);
        chk("jal_addr", imem_addr, 32'h100);

        run_instr(JR, F_JR, 1'b0, 32'hFFFF_FFFC, 0, 0);
        chk("jr_top", imem_addr, 32'hFFFF_FFFC);
        run_instr(NOP, F_NONE, 1'b0, 32'h0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);

        run_instr(JR, F_JR, 1'b0, 32'h42, 0, 0);
        chk("mis_flag", {31'b0, pc_misalign}, 32'h1);
        imem_ack = 1'b1; exec_done = 1'b1;
        for (int unsigned i = 0; i < 5; i++) cycle();
        chk("halt_req", {31'b0, imem_req}, 32'h0);
        reset = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
        cycle();
        reset = 1'b1;
        chk("mis_clear", {31'b0, pc_misalign}, 32'h0);
        chk("restart_addr", imem_addr, 32'h0);

        run_instr(NOP, F_NONE, 1'b0, 32'h0, 0, 0);
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        reset = 1'b1; imem_ack = 1'b0;
        chk("rstack_valid", {31'b0, instr_valid}, 32'h0);
        chk("rstack_addr", imem_addr, 32'h0);
        chk("rstack_instr", Instruction, 32'h0);
        cycle();

        for (int unsigned i = 0; i < 800; i++) begin
            reset       = ($urandom_range(0, 63) != 0);
            imem_ack    = ($urandom_range(0, 2) == 0);
            imem_rdata  = $urandom;
            exec_done   = ($urandom_range(0, 1) == 1);
            stall       = ($urandom_range(0, 3) == 0);
            Branch      = ($urandom_range(0, 1) == 1);
            nBranch     = ($urandom_range(0, 1) == 1);
            Jmp         = ($urandom_range(0, 5) == 0);
            Jal         = ($urandom_range(0, 5) == 0);
            Jr          = ($urandom_range(0, 7) == 0);
            Zero        = ($urandom_range(0, 1) == 1);
            Read_data_1 = ($urandom_range(0, 7) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
